instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 118 +++++++++++
 tb/tb_instruction_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder: accepts MIPS-style instruction fields over a valid/ready
// handshake, encodes them into 32-bit words and writes them sequentially into
// an instruction memory starting at address 0 of each programming session.
module instruction_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       immediate,
    input  logic [25:0]       jump_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        FULL = 2'b10
    } state_t;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;

    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    // Address width must cover exactly DEPTH words so the address never wraps.
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_params
        $error("instruction_encoder: ADDR_W must equal clog2(DEPTH)");
    end

    state_t              state_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                we_q;
    logic                full_q;
    logic                err_q;

    logic [31:0]         wdata_d;
    logic                fmt_legal;
    logic                xfer;

    // Ready depends on state and start only, never on in_valid; start wins.
    assign in_ready = (state_q == LOAD) && !start;
    assign xfer     = in_valid && in_ready;

    // Encode the presented fields according to the selected format.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        wdata_d   = 32'h0;
        fmt_legal = 1'b1;
        case (fmt)
            FMT_R:   wdata_d = {6'b000000, rs, rt, rd, shamt, funct};
            FMT_I:   wdata_d = {opcode, rs, rt, immediate};
            FMT_J:   wdata_d = {opcode, jump_target};
            default: fmt_legal = 1'b0;
        endcase
    end

    // Session FSM with registered write port, word counter and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values and ordering inside the block does not matter.
            we_q <= 1'b0;
            if (start) begin
                state_q <= LOAD;
                count_q <= '0;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
            end else if (xfer) begin
                if (fmt_legal) begin
                    we_q    <= 1'b1;
                    addr_q  <= count_q[ADDR_W-1:0];
                    wdata_q <= wdata_d;
                    count_q <= count_q + (ADDR_W + 1)'(1);
                    if (count_q == LAST_COUNT) begin
                        state_q <= FULL;
                        full_q  <= 1'b1;
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign full       = full_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed scenarios followed by random traffic, all
// checked against a session-level reference model of the encoder.
module tb_instruction_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       immediate;
    logic [25:0]       jump_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              full;
    logic              err;
    logic [ADDR_W:0]   count;

    int tests = 0;
    int fails = 0;

    // Reference model: session open flag, words written, sticky error, last write.
    bit          m_started = 0;
    int          m_count   = 0;
    bit          m_err     = 0;
    bit          m_we      = 0;
    int          m_addr    = 0;
    logic [31:0] m_data    = 32'h0;

    instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .immediate  (immediate),
        .jump_target(jump_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .full       (full),
        .err        (err),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Encoded word computed from field positions with plain arithmetic.
    function automatic logic [31:0] ref_word();
        case (fmt)
            2'b00:   return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11)
                            | (32'(shamt) << 6) | 32'(funct);
            2'b01:   return (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16)
                            | 32'(immediate);
            default: return (32'(opcode) << 26) | 32'(jump_target);
        endcase
    endfunction

    task automatic randomize_fields();
        opcode      = 6'($urandom);
        rs          = 5'($urandom);
        rt          = 5'($urandom);
        rd          = 5'($urandom);
        shamt       = 5'($urandom);
        funct       = 6'($urandom);
        immediate   = 16'($urandom);
        jump_target = 26'($urandom);
    endtask

    task automatic check_outputs(string tag);
        check({tag, ".we"},    32'(imem_we),    32'(m_we));
        check({tag, ".addr"},  32'(imem_addr),  32'(m_addr));
        check({tag, ".wdata"}, imem_wdata,      m_data);
        check({tag, ".count"}, 32'(count),      32'(m_count));
        check({tag, ".full"},  32'(full),       32'(m_started && m_count == DEPTH));
        check({tag, ".err"},   32'(err),        32'(m_err));
    endtask

    // One clock cycle of stimulus; fields must already be set by the caller.
    task automatic step(string tag, bit st, bit v, logic [1:0] f);
        bit rdy;
        logic [31:0] word;
        start    = st;
        in_valid = v;
        fmt      = f;
        #1;
        rdy  = m_started && (m_count < DEPTH) && !st;
        word = ref_word();
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        @(posedge clk);
        #1;
        m_we = 0;
        if (st) begin
            m_started = 1;
            m_count   = 0;
            m_err     = 0;
        end else if (v && rdy) begin
            if (f == 2'b11) begin
                m_err = 1;
            end else begin
                m_we    = 1;
                m_addr  = m_count;
                m_data  = word;
                m_count = m_count + 1;
            end
        end
        check_outputs(tag);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic set_r(logic [4:0] a, logic [4:0] b, logic [4:0] c, logic [4:0] sh, logic [5:0] fn);
        randomize_fields();
        rs = a; rt = b; rd = c; shamt = sh; funct = fn;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        fmt      = 2'b00;
        randomize_fields();
        #2;
        check_outputs("reset0");
        check("reset0.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_outputs("reset1");
        reset = 1'b0;

        // Fields offered before any start are ignored.
        randomize_fields();
        step("idle", 0, 1, 2'b00);

        // R-type basic write.
        step("s1.start", 1, 0, 2'b00);
        set_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        step("s1.r", 0, 1, 2'b00);
        check("s1.lit", imem_wdata, 32'h00221820);

        // I-type then J-type back to back.
        step("s2.start", 1, 0, 2'b00);
        randomize_fields();
        opcode = 6'h08; rs = 5'd1; rt = 5'd2; immediate = 16'hFFFF;
        step("s2.i", 0, 1, 2'b01);
        check("s2.i.lit", imem_wdata, 32'h2022FFFF);
        randomize_fields();
        opcode = 6'h02; jump_target = 26'h0000010;
        step("s2.j", 0, 1, 2'b10);
        check("s2.j.lit", imem_wdata, 32'h08000010);
        check("s2.j.addr", 32'(imem_addr), 32'd1);

        // Illegal format between two legal instructions.
        step("s3.start", 1, 0, 2'b00);
        randomize_fields(); step("s3.a", 0, 1, 2'b00);
        randomize_fields(); step("s3.bad", 0, 1, 2'b11);
        randomize_fields(); step("s3.b", 0, 1, 2'b01);
        check("s3.err", 32'(err), 32'd1);
        check("s3.count", 32'(count), 32'd2);

        // Five offers into a four-word memory; also start colliding with valid.
        randomize_fields(); step("s4.start", 1, 1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            randomize_fields();
            step("s4.w", 0, 1, 2'($urandom_range(0, 2)));
        end
        check("s4.full", 32'(full), 32'd1);
        check("s4.ready", 32'(in_ready), 32'd0);

        // Reach FULL with err set, then restart.
        step("s5.start", 1, 0, 2'b00);
        randomize_fields(); step("s5.bad", 0, 1, 2'b11);
        for (int i = 0; i < 4; i++) begin
            randomize_fields();
            step("s5.w", 0, 1, 2'b10);
        end
        step("s5.restart", 1, 0, 2'b00);
        check("s5.cleared", {29'd0, full, err, 2'(count)}, 32'd0);
        randomize_fields(); step("s5.first", 0, 1, 2'b00);
        check("s5.addr0", 32'(imem_addr), 32'd0);

        // Reset between edges while a write is being presented.
        randomize_fields();
        start    = 1'b0;
        in_valid = 1'b1;
        fmt      = 2'b01;
        m_data   = ref_word();
        @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        m_started = 0; m_count = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 32'h0;
        check_outputs("s6.async");
        check("s6.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_fields();
            step("s6.dead", 0, 1, 2'b00);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_fields();
            step("rnd", $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
